// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 x DATA_W registers, r0 hard-wired to zero, two read ports with write-through bypass.
// Latency: reads and write_data_wb are combinational; a write commits on the next rising clk edge (1 cycle).
// Backpressure: none; a write is accepted on every edge where write-back is enabled to a nonzero register.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_regWrite_mem_wb,
    input  logic              ctrl_memToReg_mem_wb,
    input  logic [DATA_W-1:0] read_data_from_mem_mem_wb,
    input  logic [DATA_W-1:0] alu_result_mem_wb,
    input  logic [4:0]        write_register_mem_wb,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] write_data_wb,
    output logic [31:0]       retire_count
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [31:0]       r_retire_count;
    logic              w_commit;

    // Write-back source mux; independent of the write enable so forwarding always sees it.
    assign write_data_wb = ctrl_memToReg_mem_wb ? read_data_from_mem_mem_wb : alu_result_mem_wb;

    // A write is live only when enabled and not aimed at r0; reset gating happens in the flop block.
    assign w_commit = ctrl_regWrite_mem_wb && (write_register_mem_wb != 5'd0);

    assign retire_count = r_retire_count;

    // Register array and retire counter: async clear, commit selected write-back value on live writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_retire_count <= '0;
        end else if (w_commit) begin
            r_regs[write_register_mem_wb] <= write_data_wb;
            r_retire_count                <= r_retire_count + 32'd1;
        end
    end

    // Port 1 read: zero in reset, bypass a same-cycle write, r0 always reads zero.
    always_comb begin
        read_data1 = '0;
        if (!reset) begin
            read_data1 = '0;
        end else if (w_commit && (read_reg1 == write_register_mem_wb)) begin
            read_data1 = write_data_wb;
        end else if (read_reg1 != 5'd0) begin
            read_data1 = r_regs[read_reg1];
        end
    end

    // Port 2 read: same selection as port 1 so equal addresses always return equal data.
    always_comb begin
        read_data2 = '0;
        if (!reset) begin
            read_data2 = '0;
        end else if (w_commit && (read_reg2 == write_register_mem_wb)) begin
            read_data2 = write_data_wb;
        end else if (read_reg2 != 5'd0) begin
            read_data2 = r_regs[read_reg2];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: hand-computed expectations for reset, write-back, bypass, r0 and counter wrap.
// Latency: inputs change just after a rising edge, outputs sampled 1 time unit later.
// Backpressure: not applicable.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        we;
    logic        m2r;
    logic [31:0] mem_d;
    logic [31:0] alu_d;
    logic [4:0]  waddr;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wdb;
    logic [31:0] rcnt;

    int n_vec = 0;
    int n_err = 0;

    wb_regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .ctrl_regWrite_mem_wb      (we),
        .ctrl_memToReg_mem_wb      (m2r),
        .read_data_from_mem_mem_wb (mem_d),
        .alu_result_mem_wb         (alu_d),
        .write_register_mem_wb     (waddr),
        .read_reg1                 (rr1),
        .read_reg2                 (rr2),
        .read_data1                (rd1),
        .read_data2                (rd2),
        .write_data_wb             (wdb),
        .retire_count              (rcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge, leaving room to drive/sample away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic m, input logic [31:0] md,
                         input logic [31:0] ad, input logic [4:0] a);
        we    = w;
        m2r   = m;
        mem_d = md;
        alu_d = ad;
        waddr = a;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd3);
        rr1 = 5'd3;
        rr2 = 5'd0;
        #2;
        // in reset: outputs zero, bypass suppressed, mux still live
        chk("rst_rd1_nobypass", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_cnt", rcnt, 32'h0);
        chk("rst_wdb_alu", wdb, 32'h0000_0055);
        m2r   = 1'b1;
        mem_d = 32'h0000_0066;
        #1;
        chk("rst_wdb_mem", wdb, 32'h0000_0066);
        tick();
        chk("rst_edge_nowrite", rcnt, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        reset = 1'b1;

        // write r5 from ALU, read next cycle
        tick();
        drive(1'b1, 1'b0, 32'hFFFF_0000, 32'h1234_5678, 5'd5);
        tick();
        we  = 1'b0;
        rr1 = 5'd5;
        #1;
        chk("r5_read", rd1, 32'h1234_5678);
        chk("r5_cnt", rcnt, 32'd1);

        // write r7 from memory with both ports bypassing
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 5'd7);
        rr1 = 5'd7;
        rr2 = 5'd7;
        #1;
        chk("r7_byp_rd1", rd1, 32'hDEAD_BEEF);
        chk("r7_byp_rd2", rd2, 32'hDEAD_BEEF);
        chk("r7_wdb", wdb, 32'hDEAD_BEEF);
        chk("r7_cnt_pre", rcnt, 32'd1);
        tick();
        we = 1'b0;
        #1;
        chk("r7_held_rd1", rd1, 32'hDEAD_BEEF);
        chk("r7_held_rd2", rd2, 32'hDEAD_BEEF);
        chk("r7_cnt", rcnt, 32'd2);

        // distinct ports read distinct registers
        rr1 = 5'd5;
        rr2 = 5'd7;
        #1;
        chk("dual_rd1", rd1, 32'h1234_5678);
        chk("dual_rd2", rd2, 32'hDEAD_BEEF);

        // write to r0 is discarded and not bypassed
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        rr1 = 5'd0;
        #1;
        chk("r0_nobypass", rd1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("r0_read", rd1, 32'h0);
        chk("r0_cnt", rcnt, 32'd2);

        // r9 = 9, then a disabled write to r9 must be ignored
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0009, 5'd9);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'hAAAA_5555, 5'd9);
        rr1 = 5'd9;
        #1;
        chk("r9_nobypass", rd1, 32'h0000_0009);
        chk("r9_wdb", wdb, 32'hAAAA_5555);
        tick();
        chk("r9_unchanged", rd1, 32'h0000_0009);
        chk("r9_cnt", rcnt, 32'd3);

        // fill r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b0, 32'h0, i, i[4:0]);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rr1 = 5'd31;
        rr2 = 5'd17;
        #1;
        chk("fill_r31", rd1, 32'd31);
        chk("fill_r17", rd2, 32'd17);
        chk("fill_cnt", rcnt, 32'd34);

        // pending write to r4, reset pulsed mid-cycle cancels it
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0444, 5'd4);
        rr1 = 5'd4;
        #1;
        chk("pend_byp", rd1, 32'h0000_0444);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_rd1", rd1, 32'h0);
        chk("midrst_rd2", rd2, 32'h0);
        chk("midrst_cnt", rcnt, 32'h0);
        chk("midrst_wdb", wdb, 32'h0000_0444);
        tick();
        chk("midrst_edge_cnt", rcnt, 32'h0);

        // first edge after release commits the still-pending write
        @(negedge clk);
        reset = 1'b1;
        rr2 = 5'd31;
        #1;
        chk("rel_r31_cleared", rd2, 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("rel_r4", rd1, 32'h0000_0444);
        chk("rel_cnt", rcnt, 32'd1);

        // counter wrap via backdoor preload
        @(negedge clk);
        dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", rcnt, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 32'h0000_000A, 32'h0, 5'd10);
        rr1 = 5'd10;
        tick();
        we = 1'b0;
        #1;
        chk("wrap_cnt", rcnt, 32'h0);
        chk("wrap_r10", rd1, 32'h0000_000A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // hard stop if the sequence ever stalls
    initial begin
        #20000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1);
    end

endmodule
